scores_dump_ctrl: RTL and testbench

//  Sequencer for the 40-byte class-score RAM. On inference_done it pulses the RAM write enable to latch
//  all 10 scores, then on dump_req (or automatically) streams a frame over a byte TX handshake:

---
 rtl/scores_pkg.sv | 25 ++
 rtl/scores_dump_ctrl_if.sv | 26 ++
 rtl/scores_dump_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_scores_dump_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scores_pkg.sv
// rtl/scores_pkg.sv - shared constants, state encoding for the class-score dump path
//
// Purpose: frame geometry (class count, bytes per score, header byte) and the
//          dump FSM state enum. Host-side frame parsers import this as well.
// Ports:   none (package).
package scores_pkg;

  localparam int         NUM_CLASSES     = 10;
  localparam int         BYTES_PER_SCORE = 4;
  localparam int         SCORE_BYTES     = NUM_CLASSES * BYTES_PER_SCORE;
  localparam int         ADDR_W          = 6;
  localparam logic [7:0] HDR_BYTE        = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_HDR,
    ST_FETCH,
    ST_CAPTURE,
    ST_SEND,
    ST_CSUM,
    ST_DONE
  } dump_state_e;

endpackage

// File: rtl/scores_dump_ctrl_if.sv
// rtl/scores_dump_ctrl_if.sv - byte TX handshake between the dump sequencer and the UART path
//
// Purpose: groups the TX byte stream into one bundle.
// Signals: tx_data  [7:0]  byte offered to TX
//          tx_valid        tx_data is valid
//          tx_ready        TX accepts the byte; transfer when tx_valid && tx_ready
// Modports: master (sequencer side), slave (TX side).
interface scores_dump_ctrl_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/scores_dump_ctrl.sv
// rtl/scores_dump_ctrl.sv - latch/dump sequencer for the 40-byte class-score RAM
//
// Purpose: pulses the score RAM write enable on inference_done, then streams a frame
//          (header, 40 score bytes, XOR checksum) over the TX handshake on dump_req
//          or automatically after a latch when AUTO_DUMP=1.
// Ports:   clk, rst_n         clock, asynchronous active-low reset
//          inference_done     pulse: new scores present at the RAM inputs
//          dump_req           pulse: host asks for a frame
//          ram_wr_en          1-cycle RAM write pulse
//          ram_rd_addr        RAM read address
//          ram_rd_data        RAM read data, one cycle after the address is sampled
//          tx                 byte stream (master modport)
//          busy               frame in progress (header through checksum)
//          dump_done          1-cycle pulse after the checksum byte transfers
//          scores_valid       RAM holds a latched score set
module scores_dump_ctrl #(
  parameter int         NUM_CLASSES     = scores_pkg::NUM_CLASSES,
  parameter int         BYTES_PER_SCORE = scores_pkg::BYTES_PER_SCORE,
  parameter int         ADDR_W          = scores_pkg::ADDR_W,
  parameter logic [7:0] HDR_BYTE        = scores_pkg::HDR_BYTE,
  parameter bit         AUTO_DUMP       = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inference_done,
  input  logic                     dump_req,
  output logic                     ram_wr_en,
  output logic [ADDR_W-1:0]        ram_rd_addr,
  input  logic [7:0]               ram_rd_data,
  scores_dump_ctrl_if.master       tx,
  output logic                     busy,
  output logic                     dump_done,
  output logic                     scores_valid
);

  localparam int                SCORE_BYTES = NUM_CLASSES * BYTES_PER_SCORE;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(SCORE_BYTES - 1);

  import scores_pkg::*;

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [7:0]        csum_q, csum_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              dump_done_q, dump_done_d;
  logic              ram_wr_en_q, ram_wr_en_d;
  logic              scores_valid_q, scores_valid_d;
  logic              pending_q, pending_d;
  logic              tx_fire;
  logic              start_frame;

  assign tx_fire = tx_valid_q && tx.tx_ready;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    tx_data_d      = tx_data_q;
    tx_valid_d     = tx_valid_q;
    csum_d         = csum_q;
    busy_d         = busy_q;
    dump_done_d    = 1'b0;
    ram_wr_en_d    = 1'b0;
    scores_valid_d = scores_valid_q;
    pending_d      = pending_q;
    start_frame    = 1'b0;

    // A new score set arriving mid-frame is deferred so the RAM is never
    // rewritten while it is being read out; repeated pulses collapse to one.
    if (inference_done && state_q != ST_IDLE && state_q != ST_LATCH) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (inference_done || pending_q) begin
          state_d     = ST_LATCH;
          ram_wr_en_d = 1'b1;
        end else if (dump_req && scores_valid_q) begin
          start_frame = 1'b1;
        end
      end
      ST_LATCH: begin
        scores_valid_d = 1'b1;
        pending_d      = 1'b0;
        if (AUTO_DUMP) begin
          start_frame = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        tx_data_d  = ram_rd_data;
        csum_d     = csum_q ^ ram_rd_data;
        tx_valid_d = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (tx_fire) begin
          if (addr_q == LAST_ADDR) begin
            tx_data_d  = csum_q;
            tx_valid_d = 1'b1;
            state_d    = ST_CSUM;
          end else begin
            tx_valid_d = 1'b0;
            addr_d     = addr_q + 1'b1;
            state_d    = ST_FETCH;
          end
        end
      end
      ST_CSUM: begin
        if (tx_fire) begin
          tx_valid_d  = 1'b0;
          busy_d      = 1'b0;
          dump_done_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_frame) begin
      state_d    = ST_HDR;
      tx_data_d  = HDR_BYTE;
      tx_valid_d = 1'b1;
      busy_d     = 1'b1;
      csum_d     = 8'h00;
      addr_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      tx_data_q      <= 8'h00;
      tx_valid_q     <= 1'b0;
      csum_q         <= 8'h00;
      busy_q         <= 1'b0;
      dump_done_q    <= 1'b0;
      ram_wr_en_q    <= 1'b0;
      scores_valid_q <= 1'b0;
      pending_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      csum_q         <= csum_d;
      busy_q         <= busy_d;
      dump_done_q    <= dump_done_d;
      ram_wr_en_q    <= ram_wr_en_d;
      scores_valid_q <= scores_valid_d;
      pending_q      <= pending_d;
    end
  end

  assign ram_rd_addr  = addr_q;
  assign ram_wr_en    = ram_wr_en_q;
  assign tx.tx_data   = tx_data_q;
  assign tx.tx_valid  = tx_valid_q;
  assign busy         = busy_q;
  assign dump_done    = dump_done_q;
  assign scores_valid = scores_valid_q;

endmodule

// File: tb/tb_scores_dump_ctrl.sv
// tb/tb_scores_dump_ctrl.sv - scoreboard bench for scores_dump_ctrl
//
// Purpose: dut0 (manual dump) and dut1 (AUTO_DUMP=1) with behavioural score RAMs;
//          expected frame bytes are queued when a dump is requested and popped on
//          each TX transfer.
// Ports:   none (top-level bench).
module tb_scores_dump_ctrl;
  import scores_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              inf0, req0, wr0, busy0, done0, sv0;
  logic              inf1, req1, wr1, busy1, done1, sv1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [7:0]        rd0, rd1;

  scores_dump_ctrl_if tx0 ();
  scores_dump_ctrl_if tx1 ();

  scores_dump_ctrl #(.AUTO_DUMP(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .inference_done(inf0), .dump_req(req0),
    .ram_wr_en(wr0), .ram_rd_addr(addr0), .ram_rd_data(rd0), .tx(tx0),
    .busy(busy0), .dump_done(done0), .scores_valid(sv0)
  );

  scores_dump_ctrl #(.AUTO_DUMP(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .inference_done(inf1), .dump_req(req1),
    .ram_wr_en(wr1), .ram_rd_addr(addr1), .ram_rd_data(rd1), .tx(tx1),
    .busy(busy1), .dump_done(done1), .scores_valid(sv1)
  );

  logic [31:0] scores0 [NUM_CLASSES];
  logic [31:0] scores1 [NUM_CLASSES];
  logic [31:0] exp0    [NUM_CLASSES];
  logic [7:0]  ram0 [64];
  logic [7:0]  ram1 [64];

  int checks = 0;
  int errors = 0;
  logic [7:0] sb0 [$];
  int bytes0 = 0, wr_cnt0 = 0, done_cnt0 = 0;
  bit rdy_rand0 = 1'b0;

  // Behavioural score RAMs: write all bytes on ram_wr_en, registered read.
  initial begin
    for (int i = 0; i < 64; i++) begin ram0[i] = 8'h00; ram1[i] = 8'h00; end
    forever begin
      @(posedge clk);
      if (wr0 === 1'b1)
        for (int c = 0; c < NUM_CLASSES; c++)
          for (int b = 0; b < BYTES_PER_SCORE; b++)
            ram0[c*BYTES_PER_SCORE+b] <= scores0[c][8*b +: 8];
      if (wr1 === 1'b1)
        for (int c = 0; c < NUM_CLASSES; c++)
          for (int b = 0; b < BYTES_PER_SCORE; b++)
            ram1[c*BYTES_PER_SCORE+b] <= scores1[c][8*b +: 8];
      rd0 <= ram0[addr0];
      rd1 <= ram1[addr1];
    end
  end

  initial begin
    tx0.tx_ready = 1'b1;
    tx1.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx0.tx_ready = rdy_rand0 ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // dut0 monitor: scoreboard pops, hold-while-stalled check, event counters.
  initial begin
    logic       stall;
    logic [7:0] stall_data, exp;
    stall = 1'b0;
    stall_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        stall = 1'b0;
      end else begin
        if (wr0 === 1'b1) wr_cnt0++;
        if (done0 === 1'b1) done_cnt0++;
        if (stall) begin
          checks++;
          if (tx0.tx_valid !== 1'b1 || tx0.tx_data !== stall_data) begin
            errors++;
            $display("FAIL hold_stable valid=%b data=%02h required valid=1 data=%02h",
                     tx0.tx_valid, tx0.tx_data, stall_data);
          end
        end
        if (tx0.tx_valid === 1'b1 && tx0.tx_ready === 1'b1) begin
          checks++;
          if (sb0.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte got=%02h required=none", tx0.tx_data);
          end else begin
            exp = sb0.pop_front();
            if (tx0.tx_data !== exp) begin
              errors++;
              $display("FAIL frame_byte idx=%0d got=%02h required=%02h", bytes0, tx0.tx_data, exp);
            end
          end
          bytes0++;
        end
        stall = (tx0.tx_valid === 1'b1 && tx0.tx_ready !== 1'b1);
        stall_data = tx0.tx_data;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_inf0();
    inf0 = 1'b1; tick(1); inf0 = 1'b0;
  endtask

  task automatic pulse_req0();
    req0 = 1'b1; tick(1); req0 = 1'b0;
  endtask

  task automatic push_frame0();
    logic [7:0] cs, v;
    cs = 8'h00;
    sb0.push_back(HDR_BYTE);
    for (int c = 0; c < NUM_CLASSES; c++)
      for (int b = 0; b < BYTES_PER_SCORE; b++) begin
        v = exp0[c][8*b +: 8];
        cs = cs ^ v;
        sb0.push_back(v);
      end
    sb0.push_back(cs);
  endtask

  task automatic wait_done0(input int budget, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_dump_done got=timeout required=pulse within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_bytes0(input int target, input int budget);
    for (int i = 0; i < budget && bytes0 < target; i++) @(negedge clk);
    checks++;
    if (bytes0 < target) begin
      errors++;
      $display("FAIL wait_bytes got=%0d required=%0d", bytes0, target);
    end
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (sb0.size() != 0) begin
      errors++;
      $display("FAIL %s_frame_complete got=%0d bytes left required=0", name, sb0.size());
      sb0.delete();
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (tx0.tx_valid !== 1'b0 || busy0 !== 1'b0 || sv0 !== 1'b0 || wr0 !== 1'b0 ||
        done0 !== 1'b0 || addr0 !== '0 || tx0.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL %s_dut0 got valid=%b busy=%b sv=%b wr=%b done=%b addr=%0d data=%02h required all 0",
               name, tx0.tx_valid, busy0, sv0, wr0, done0, addr0, tx0.tx_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inf0 = 1'b0; req0 = 1'b0; inf1 = 1'b0; req1 = 1'b0;
    for (int c = 0; c < NUM_CLASSES; c++) begin scores0[c] = '0; scores1[c] = '0; exp0[c] = '0; end
    tick(3);
    check_idle_outputs("reset");
    checks++;
    if (tx1.tx_valid !== 1'b0 || busy1 !== 1'b0 || sv1 !== 1'b0 || wr1 !== 1'b0 || addr1 !== '0) begin
      errors++;
      $display("FAIL reset_dut1 got valid=%b busy=%b sv=%b wr=%b addr=%0d required all 0",
               tx1.tx_valid, busy1, sv1, wr1, addr1);
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_req_without_scores(input string name);
    int viol;
    viol = 0;
    pulse_req0();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx0.tx_valid !== 1'b0 || busy0 !== 1'b0) viol++;
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL %s got=%0d active cycles required=0", name, viol);
    end
    tick(1);
  endtask

  task automatic test_basic_dump();
    int w, d;
    for (int c = 0; c < NUM_CLASSES; c++) begin scores0[c] = 32'(c); exp0[c] = 32'(c); end
    w = wr_cnt0;
    pulse_inf0();
    tick(3);
    checks++;
    if (wr_cnt0 != w + 1) begin
      errors++; $display("FAIL basic_wr_pulses got=%0d required=%0d", wr_cnt0 - w, 1);
    end
    checks++;
    if (sv0 !== 1'b1) begin
      errors++; $display("FAIL basic_scores_valid got=%b required=1", sv0);
    end
    d = done_cnt0;
    push_frame0();
    pulse_req0();
    checks++;
    if (tx0.tx_valid !== 1'b1 || tx0.tx_data !== HDR_BYTE || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL basic_hdr_latency got valid=%b data=%02h busy=%b required valid=1 data=aa busy=1",
               tx0.tx_valid, tx0.tx_data, busy0);
    end
    wait_done0(300, "basic");
    tick(2);
    check_sb_empty("basic");
    checks++;
    if (done_cnt0 != d + 1 || busy0 !== 1'b0 || wr_cnt0 != w + 1) begin
      errors++;
      $display("FAIL basic_after_frame got done=%0d busy=%b wr=%0d required done=1 busy=0 wr=1",
               done_cnt0 - d, busy0, wr_cnt0 - w);
    end
  endtask

  task automatic test_random_ready();
    for (int c = 0; c < NUM_CLASSES; c++) begin
      scores0[c] = (c == 0) ? 32'hFFFF_FFFF : 32'h0;
      exp0[c] = scores0[c];
    end
    pulse_inf0();
    tick(3);
    rdy_rand0 = 1'b1;
    push_frame0();
    pulse_req0();
    wait_done0(900, "random_ready");
    rdy_rand0 = 1'b0;
    tick(2);
    check_sb_empty("random_ready");
  endtask

  task automatic test_pending_latch();
    int w, start;
    start = bytes0;
    push_frame0();
    pulse_req0();
    wait_bytes0(start + 21, 300);
    for (int c = 0; c < NUM_CLASSES; c++) scores0[c] = $urandom;
    w = wr_cnt0;
    pulse_inf0();
    tick(2);
    pulse_inf0();
    wait_done0(300, "pending");
    checks++;
    if (wr_cnt0 != w) begin
      errors++; $display("FAIL pending_midframe_write got=%0d required=0", wr_cnt0 - w);
    end
    tick(6);
    checks++;
    if (wr_cnt0 != w + 1) begin
      errors++; $display("FAIL pending_latch_after_done got=%0d required=1", wr_cnt0 - w);
    end
    check_sb_empty("pending_old");
    for (int c = 0; c < NUM_CLASSES; c++) exp0[c] = scores0[c];
    push_frame0();
    pulse_req0();
    wait_done0(300, "pending_new");
    tick(2);
    check_sb_empty("pending_new");
  endtask

  task automatic test_reset_midframe();
    int start;
    start = bytes0;
    push_frame0();
    pulse_req0();
    wait_bytes0(start + 11, 300);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midframe_reset");
    sb0.delete();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    test_req_without_scores("req_after_reset");
  endtask

  task automatic test_auto_dump();
    logic [7:0] ef [42];
    logic [7:0] cs;
    int idx;
    bit seen;
    cs = 8'h00;
    ef[0] = HDR_BYTE;
    for (int c = 0; c < NUM_CLASSES; c++) scores1[c] = $urandom;
    for (int c = 0; c < NUM_CLASSES; c++)
      for (int b = 0; b < BYTES_PER_SCORE; b++) begin
        ef[1 + c*BYTES_PER_SCORE + b] = scores1[c][8*b +: 8];
        cs = cs ^ scores1[c][8*b +: 8];
      end
    ef[41] = cs;
    idx = 0;
    seen = 1'b0;
    inf1 = 1'b1; tick(1); inf1 = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (tx1.tx_valid === 1'b1 && tx1.tx_ready === 1'b1) begin
        checks++;
        if (idx >= 42) begin
          errors++; $display("FAIL auto_extra_byte got=%02h required=none", tx1.tx_data);
        end else if (tx1.tx_data !== ef[idx]) begin
          errors++; $display("FAIL auto_byte idx=%0d got=%02h required=%02h", idx, tx1.tx_data, ef[idx]);
        end
        idx++;
      end
      if (done1 === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || idx != 42) begin
      errors++; $display("FAIL auto_frame got done=%b bytes=%0d required done=1 bytes=42", seen, idx);
    end
  endtask

  initial begin
    test_reset();
    test_req_without_scores("req_without_scores");
    test_basic_dump();
    test_random_ready();
    test_pending_latch();
    test_reset_midframe();
    test_auto_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
